// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage next-PC sequencer.
package pc_seq_pkg;

   // Sequencer state, exported on the State port with this encoding.
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   // Reason recorded alongside Epc.
   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_EXT      = 2'd1,
      CAUSE_MISALIGN = 2'd2
   } cause_t;

   // Decision taken in a fetching cycle, lower value wins.
   localparam logic [2:0] PRI_NONE      = 3'd0;
   localparam logic [2:0] PRI_EXCEPTION = 3'd1;
   localparam logic [2:0] PRI_BRANCH    = 3'd2;
   localparam logic [2:0] PRI_JUMP      = 3'd3;
   localparam logic [2:0] PRI_HALT      = 3'd4;
   localparam logic [2:0] PRI_HOLD      = 3'd5;
   localparam logic [2:0] PRI_SEQ       = 3'd6;

endpackage

// File: rtl/pc_sequencer_register.sv
// Generic n-bit register: synchronous active-low clear, active-low load enable.
module Register #(
   parameter int n = 32
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Enable,
   input  logic [n-1:0] D,
   output logic [n-1:0] Q
);

   // Clear on reset, otherwise capture D whenever Enable is low.
   always_ff @(posedge Clk) begin
      if (!Reset)
         Q <= '0;
      else if (!Enable)
         Q <= D;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: boot, sequential fetch, stall,
// branch/jump redirect with alignment check, exception vectoring with EPC
// capture, halt/resume, and a multi-cycle pipeline flush after redirects.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int           N            = 32,
   parameter logic [N-1:0] RESET_VECTOR = '0,
   parameter logic [N-1:0] EXC_VECTOR   = N'('h80),
   parameter int           INC          = 4,
   parameter int           ALIGN_BITS   = 2,
   parameter int           FLUSH_CYCLES = 2
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [N-1:0] Pc,
   input  logic         FetchReady,
   input  logic         Stall,
   input  logic         BranchTaken,
   input  logic [N-1:0] BranchTarget,
   input  logic         Jump,
   input  logic [N-1:0] JumpTarget,
   input  logic         Exception,
   input  logic         Halt,
   input  logic         Resume,
   output logic [N-1:0] PcNext,
   output logic         PcEnable_n,
   output logic         Flush,
   output logic         FetchValid,
   output logic [N-1:0] Epc,
   output logic [1:0]   Cause,
   output logic [1:0]   State
);

   localparam int           CNT_W      = $clog2(FLUSH_CYCLES + 1);
   localparam logic [N-1:0] ALIGN_MASK = N'((64'd1 << ALIGN_BITS) - 64'd1);
   localparam logic [N-1:0] INC_N      = N'(INC);

   state_t             state, state_next;
   cause_t             cause, cause_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic [2:0]         pri;
   logic [N-1:0]       target;
   logic               take_vec;
   logic               take_redir;
   logic               capture;

   function automatic logic misaligned(input logic [N-1:0] t);
      return |(t & ALIGN_MASK);
   endfunction

   // Control registers: state, flush countdown, exception cause.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state <= ST_BOOT;
         cnt   <= '0;
         cause <= CAUSE_NONE;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (capture)
            cause <= cause_next;
      end
   end

   // Next-state and PC-register control decode.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      cause_next = cause;
      PcNext     = Pc;
      PcEnable_n = 1'b1;
      Flush      = 1'b0;
      FetchValid = 1'b0;
      capture    = 1'b0;
      take_vec   = 1'b0;
      take_redir = 1'b0;
      pri        = PRI_NONE;
      target     = BranchTarget;

      case (state)
         ST_BOOT: begin
            PcNext     = RESET_VECTOR;
            PcEnable_n = 1'b0;
            state_next = ST_RUN;
         end
         ST_RUN, ST_FLUSH: begin
            FetchValid = 1'b1;
            Flush      = (state == ST_FLUSH);
            // In FLUSH the branch/jump/halt requests belong to killed work.
            if (Exception)
               pri = PRI_EXCEPTION;
            else if (state == ST_RUN && BranchTaken)
               pri = PRI_BRANCH;
            else if (state == ST_RUN && Jump)
               pri = PRI_JUMP;
            else if (state == ST_RUN && Halt)
               pri = PRI_HALT;
            else if (Stall || !FetchReady)
               pri = PRI_HOLD;
            else
               pri = PRI_SEQ;
         end
         ST_HALT: begin
            if (Exception)
               pri = PRI_EXCEPTION;
            else if (Resume)
               state_next = ST_RUN;
         end
         default: state_next = ST_BOOT;
      endcase

      case (pri)
         PRI_EXCEPTION: begin
            take_vec   = 1'b1;
            cause_next = CAUSE_EXT;
         end
         PRI_BRANCH, PRI_JUMP: begin
            target = (pri == PRI_BRANCH) ? BranchTarget : JumpTarget;
            if (misaligned(target)) begin
               take_vec   = 1'b1;
               cause_next = CAUSE_MISALIGN;
            end else begin
               take_redir = 1'b1;
            end
         end
         PRI_HALT: state_next = ST_HALT;
         PRI_SEQ: begin
            PcNext     = Pc + INC_N;
            PcEnable_n = 1'b0;
         end
         default: ;
      endcase

      // Plain cycles inside FLUSH count down toward RUN.
      if (state == ST_FLUSH && (pri == PRI_HOLD || pri == PRI_SEQ)) begin
         cnt_next = cnt - CNT_W'(1);
         if (cnt <= CNT_W'(1))
            state_next = ST_RUN;
      end

      if (take_vec) begin
         PcNext  = EXC_VECTOR;
         capture = 1'b1;
      end else if (take_redir) begin
         PcNext = target;
      end

      if (take_vec || take_redir) begin
         PcEnable_n = 1'b0;
         Flush      = 1'b1;
         cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
         state_next = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
      end

      // Reset overrides everything visible to the PC register and pipeline.
      if (!Reset) begin
         PcNext     = RESET_VECTOR;
         PcEnable_n = 1'b1;
         Flush      = 1'b0;
         FetchValid = 1'b0;
         capture    = 1'b0;
      end
   end

   Register #(.n(N)) u_epc (
      .Clk    (Clk),
      .Reset  (Reset),
      .Enable (~capture),
      .D      (Pc),
      .Q      (Epc)
   );

   assign Cause = cause;
   assign State = state;

endmodule
